// File: rtl/kw_arb_pkg.sv
// kw_arb_pkg: shared types and default widths for the arbiter client slice
package kw_arb_pkg;
  typedef enum logic [1:0] {ARB_CL_IDLE, ARB_CL_REQ, ARB_CL_BURST} arb_client_state_t;
  localparam int W_DEF = 32;
  localparam int LEN_W_DEF = 8;
  localparam int WAIT_W_DEF = 10;
  localparam int STARVE_LIM_DEF = 512;
endpackage

// File: rtl/kw_arb_client_if.sv
// kw_arb_client_if: arbiter request/lock/grant pair plus the shared-bus beat signals
interface kw_arb_client_if import kw_arb_pkg::*; #(parameter int W = W_DEF);
  logic request;
  logic lock;
  logic grant;
  logic out_valid;
  logic [W-1:0] out_data;
  logic out_last;
  modport master(output request, lock, out_valid, out_data, out_last, input grant);
  modport slave(input request, lock, out_valid, out_data, out_last, output grant);
endinterface

// File: rtl/kw_sat_counter.sv
// kw_sat_counter: up counter that sticks at all-ones, with synchronous clear
module kw_sat_counter #(parameter int WIDTH = 10) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/kw_arb_client.sv
// kw_arb_client: requester agent holding the arbiter grant via lock for a whole burst
module kw_arb_client import kw_arb_pkg::*; #(
  parameter int W = W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int WAIT_W = WAIT_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  kw_arb_client_if.master   bus,
  output logic              busy,
  output logic              starved,
  output logic [WAIT_W-1:0] wait_cnt
);
  localparam logic [1:0] IDLE = ARB_CL_IDLE;
  localparam logic [1:0] REQ = ARB_CL_REQ;
  localparam logic [1:0] BURST = ARB_CL_BURST;
  logic [1:0] state;
  logic [LEN_W-1:0] remaining;
  logic req_q, lock_q, xfer, last, load;
  assign xfer = req_q & bus.grant & in_valid;
  assign last = remaining == '0;
  assign load = (state == IDLE) & cmd_valid;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign in_ready = xfer;
  assign bus.out_valid = xfer;
  assign bus.out_data = in_data;
  assign bus.out_last = xfer & last;
  assign bus.request = req_q;
  assign bus.lock = lock_q;
  assign starved = wait_cnt >= WAIT_W'(STARVE_LIM);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      req_q <= 1'b0;
      lock_q <= 1'b0;
      remaining <= '0;
    end else if (load) begin
      state <= REQ;
      req_q <= 1'b1;
      lock_q <= |cmd_len;
      remaining <= cmd_len;
    end else if (busy && xfer) begin
      state <= last ? IDLE : BURST;
      req_q <= !last;
      lock_q <= lock_q & !last;
      remaining <= last ? remaining : remaining - 1'b1;
    end
  kw_sat_counter #(.WIDTH(WAIT_W)) u_wait (
    .clock(clock),
    .reset_n(reset_n),
    .clear(load),
    .inc((state == REQ) & !xfer),
    .count(wait_cnt)
  );
endmodule
